// File: rtl/clk_bringup_sequencer.sv
// Power-up and recovery sequencer for the SI5324 jitter cleaner and GTX
// reference-clock path: SI5324/I2C-mux reset, I2C auto-config trigger,
// filtered QPLL lock wait, GTX soft-reset release, with bounded retries.
module clk_bringup_sequencer #(
  parameter int unsigned RST_HOLD_CYC     = 4000,
  parameter int unsigned RECOVER_CYC      = 4000,
  parameter int unsigned CFG_PULSE_CYC    = 4000,
  parameter int unsigned CFG_TIMEOUT_CYC  = 2000000,
  parameter int unsigned LOCK_FILTER_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 20000000,
  parameter int unsigned DONE_TIMEOUT_CYC = 20000000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       cfg_done,
  input  logic       qpll_lock,
  input  logic       tx_rst_done,
  input  logic       rx_rst_done,
  output logic       si_rst_n,
  output logic       iic_mux_rst_n,
  output logic       reconfig,
  output logic       gt_soft_reset,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_out
);

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned FILT_W  = $clog2(LOCK_FILTER_CYC + 1);
  localparam int unsigned RETRY_W = 4;

  localparam logic [TIMER_W-1:0] RST_HOLD_LAST  = TIMER_W'(RST_HOLD_CYC - 1);
  localparam logic [TIMER_W-1:0] RECOVER_LAST   = TIMER_W'(RECOVER_CYC - 1);
  localparam logic [TIMER_W-1:0] CFG_PULSE_LAST = TIMER_W'(CFG_PULSE_CYC - 1);
  localparam logic [TIMER_W-1:0] CFG_TO_LAST    = TIMER_W'(CFG_TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] LOCK_TO_LAST   = TIMER_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] DONE_TO_LAST   = TIMER_W'(DONE_TIMEOUT_CYC - 1);
  localparam logic [FILT_W-1:0]  FILT_LAST      = FILT_W'(LOCK_FILTER_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX      = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT      = '1;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_RECOVER    = 3'd1,
    S_CONFIG     = 3'd2,
    S_CFG_WAIT   = 3'd3,
    S_LOCK_WAIT  = 3'd4,
    S_GT_RELEASE = 3'd5,
    S_READY      = 3'd6,
    S_FAULT      = 3'd7
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [FILT_W-1:0]    filter;
  logic [FILT_W-1:0]    filter_nxt;
  logic [RETRY_W-1:0]   retry_nxt;
  logic [RETRY_W-1:0]   retry_inc;
  logic                 fail;
  logic                 jump;

  // Next-state, lock filter and retry bookkeeping; restart overrides everything.
  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_cnt;
    filter_nxt = '0;
    fail       = 1'b0;
    retry_inc  = (retry_cnt == RETRY_SAT) ? retry_cnt : retry_cnt + RETRY_W'(1);
    case (state)
      S_RESET_HOLD: if (timer == RST_HOLD_LAST)  state_nxt = S_RECOVER;
      S_RECOVER:    if (timer == RECOVER_LAST)   state_nxt = S_CONFIG;
      S_CONFIG:     if (timer == CFG_PULSE_LAST) state_nxt = S_CFG_WAIT;
      S_CFG_WAIT: begin
        if (cfg_done)                  state_nxt = S_LOCK_WAIT;
        else if (timer == CFG_TO_LAST) fail = 1'b1;
      end
      S_LOCK_WAIT: begin
        filter_nxt = qpll_lock ? filter + FILT_W'(1) : '0;
        if (qpll_lock && (filter == FILT_LAST)) state_nxt = S_GT_RELEASE;
        else if (timer == LOCK_TO_LAST)         fail = 1'b1;
      end
      S_GT_RELEASE: begin
        if (tx_rst_done && rx_rst_done) state_nxt = S_READY;
        else if (timer == DONE_TO_LAST) fail = 1'b1;
      end
      S_READY:      if (!qpll_lock) fail = 1'b1;
      S_FAULT:      state_nxt = S_FAULT;
      default:      state_nxt = S_RESET_HOLD;
    endcase
    if (fail) begin
      retry_nxt = retry_inc;
      state_nxt = (retry_inc == RETRY_MAX) ? S_FAULT : S_RESET_HOLD;
    end
    if (restart) begin
      retry_nxt = '0;
      state_nxt = S_RESET_HOLD;
    end
    jump = restart | fail | (state_nxt != state);
  end

  // State, timer, filter and Moore outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_RESET_HOLD;
      timer         <= '0;
      filter        <= '0;
      retry_cnt     <= '0;
      si_rst_n      <= 1'b0;
      reconfig      <= 1'b0;
      gt_soft_reset <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= jump ? '0 : timer + TIMER_W'(1);
      filter        <= jump ? '0 : filter_nxt;
      retry_cnt     <= retry_nxt;
      si_rst_n      <= !((state_nxt == S_RESET_HOLD) || (state_nxt == S_FAULT));
      reconfig      <= (state_nxt == S_CONFIG);
      gt_soft_reset <= !((state_nxt == S_GT_RELEASE) || (state_nxt == S_READY));
      ready         <= (state_nxt == S_READY);
      fault         <= (state_nxt == S_FAULT);
    end
  end

  assign iic_mux_rst_n = si_rst_n;
  assign state_out     = state;

endmodule

// File: tb/tb_clk_bringup_sequencer.sv
// Bench for clk_bringup_sequencer: directed scenarios plus randomized inputs,
// all checked against a phase/duration reference model.
module tb_clk_bringup_sequencer;

  localparam int RH = 4, RC = 4, CP = 2, CT = 20, LF = 3, LT = 20, DT = 20, MR = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       restart = 1'b0;
  logic       cfg_done = 1'b0;
  logic       qpll_lock = 1'b0;
  logic       tx_rst_done = 1'b0;
  logic       rx_rst_done = 1'b0;
  logic       si_rst_n;
  logic       iic_mux_rst_n;
  logic       reconfig;
  logic       gt_soft_reset;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;

  // Model: phase index, cycles already spent in phase, lock streak, retries.
  int m_phase, m_t, m_f, m_r;
  int cyc;

  always #5 clk = ~clk;

  clk_bringup_sequencer #(
    .RST_HOLD_CYC(RH), .RECOVER_CYC(RC), .CFG_PULSE_CYC(CP),
    .CFG_TIMEOUT_CYC(CT), .LOCK_FILTER_CYC(LF), .LOCK_TIMEOUT_CYC(LT),
    .DONE_TIMEOUT_CYC(DT), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .cfg_done(cfg_done),
    .qpll_lock(qpll_lock), .tx_rst_done(tx_rst_done), .rx_rst_done(rx_rst_done),
    .si_rst_n(si_rst_n), .iic_mux_rst_n(iic_mux_rst_n), .reconfig(reconfig),
    .gt_soft_reset(gt_soft_reset), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt), .state_out(state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_t = 0; m_f = 0; m_r = 0; cyc = 0;
  endtask

  // One clock edge of the reference model, using the inputs present at the edge.
  task automatic model_edge();
    int  nxt;
    int  streak;
    bit  fail_ev;
    nxt = m_phase; streak = 0; fail_ev = 1'b0;
    case (m_phase)
      0: if (m_t + 1 >= RH) nxt = 1;
      1: if (m_t + 1 >= RC) nxt = 2;
      2: if (m_t + 1 >= CP) nxt = 3;
      3: if (cfg_done) nxt = 4; else if (m_t + 1 >= CT) fail_ev = 1'b1;
      4: begin
        streak = qpll_lock ? m_f + 1 : 0;
        if (streak >= LF) nxt = 5; else if (m_t + 1 >= LT) fail_ev = 1'b1;
      end
      5: if (tx_rst_done && rx_rst_done) nxt = 6; else if (m_t + 1 >= DT) fail_ev = 1'b1;
      6: if (!qpll_lock) fail_ev = 1'b1;
      default: ;
    endcase
    if (fail_ev) begin
      m_r = (m_r < 15) ? m_r + 1 : 15;
      nxt = (m_r == MR) ? 7 : 0;
    end
    if (restart) begin
      m_r = 0;
      nxt = 0;
    end
    if (restart || fail_ev || nxt != m_phase) begin
      m_t = 0; m_f = 0;
    end else begin
      m_t++; m_f = streak;
    end
    m_phase = nxt;
    cyc++;
  endtask

  task automatic check_all();
    check("state_out",     32'(state_out),     32'(m_phase));
    check("si_rst_n",      32'(si_rst_n),      32'((m_phase == 0 || m_phase == 7) ? 0 : 1));
    check("iic_mux_rst_n", 32'(iic_mux_rst_n), 32'((m_phase == 0 || m_phase == 7) ? 0 : 1));
    check("reconfig",      32'(reconfig),      32'(m_phase == 2));
    check("gt_soft_reset", 32'(gt_soft_reset), 32'((m_phase == 5 || m_phase == 6) ? 0 : 1));
    check("ready",         32'(ready),         32'(m_phase == 6));
    check("fault",         32'(fault),         32'(m_phase == 7));
    check("retry_cnt",     32'(retry_cnt),     32'(m_r));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    restart = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
  endtask

  task automatic set_all_good();
    cfg_done = 1'b1; qpll_lock = 1'b1; tx_rst_done = 1'b1; rx_rst_done = 1'b1;
  endtask

  initial begin
    int first_si, first_cfg, first_gt, first_ready, first_rel, rel;

    // Scenario 1: clean bring-up with all inputs good.
    set_all_good();
    do_reset();
    first_si = -1; first_cfg = -1; first_gt = -1; first_ready = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (si_rst_n && first_si < 0) first_si = cyc;
      if (reconfig && first_cfg < 0) first_cfg = cyc;
      if (!gt_soft_reset && first_gt < 0) first_gt = cyc;
      if (ready && first_ready < 0) first_ready = cyc;
    end
    check("s1_si_rise_cycle", 32'(first_si), 32'(4));
    check("s1_reconfig_cycle", 32'(first_cfg), 32'(8));
    check("s1_gt_release_cycle", 32'(first_gt), 32'(14));
    check("s1_ready_cycle", 32'(first_ready), 32'(15));
    check("s1_retry", 32'(retry_cnt), 32'(0));

    // Scenario 2: one-cycle lock glitch right after LOCK_WAIT entry.
    do_reset();
    first_rel = -1;
    for (int i = 0; i < 22; i++) begin
      qpll_lock = (cyc == 12) ? 1'b0 : 1'b1;
      tick();
      if (state_out == 3'd5 && first_rel < 0) first_rel = cyc;
    end
    qpll_lock = 1'b1;
    check("s2_gt_release_cycle", 32'(first_rel), 32'(16));

    // Scenario 3: cfg_done never arrives; two timeouts reach FAULT.
    cfg_done = 1'b0;
    do_reset();
    for (int i = 0; i < 62; i++) begin
      tick();
      if (cyc == 30) begin
        check("s3_retry_after_first", 32'(retry_cnt), 32'(1));
        check("s3_state_after_first", 32'(state_out), 32'(0));
      end
      if (cyc == 60) begin
        check("s3_fault", 32'(fault), 32'(1));
        check("s3_retry_fault", 32'(retry_cnt), 32'(2));
        check("s3_si_in_fault", 32'(si_rst_n), 32'(0));
        check("s3_gt_in_fault", 32'(gt_soft_reset), 32'(1));
      end
    end

    // Scenario 5a: restart out of FAULT.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("s5a_state", 32'(state_out), 32'(0));
    check("s5a_retry", 32'(retry_cnt), 32'(0));
    check("s5a_fault", 32'(fault), 32'(0));

    // Scenario 5b: restart coincident with the second CFG_WAIT timeout.
    rel = 0;
    for (int i = 0; i < 60; i++) begin
      restart = (rel == 59) ? 1'b1 : 1'b0;
      tick();
      rel++;
    end
    restart = 1'b0;
    check("s5b_state", 32'(state_out), 32'(0));
    check("s5b_retry", 32'(retry_cnt), 32'(0));
    check("s5b_fault", 32'(fault), 32'(0));

    // Scenario 4: lock drops for one cycle while READY.
    set_all_good();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      qpll_lock = (cyc == 20) ? 1'b0 : 1'b1;
      tick();
    end
    qpll_lock = 1'b1;
    check("s4_ready_dropped", 32'(ready), 32'(0));
    check("s4_state", 32'(state_out), 32'(0));
    check("s4_retry", 32'(retry_cnt), 32'(1));
    for (int i = 0; i < 15; i++) tick();
    check("s4_ready_again", 32'(ready), 32'(1));
    check("s4_retry_kept", 32'(retry_cnt), 32'(1));

    // Scenario 6: asynchronous reset pulse in the middle of CONFIG.
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    check("s6_in_config", 32'(reconfig), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_reconfig", 32'(reconfig), 32'(0));
    check("s6_async_si", 32'(si_rst_n), 32'(0));
    check("s6_async_gt", 32'(gt_soft_reset), 32'(1));
    check("s6_async_state", 32'(state_out), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
    first_ready = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (ready && first_ready < 0) first_ready = cyc;
    end
    check("s6_ready_cycle", 32'(first_ready), 32'(15));

    // Randomized inputs against the model, with occasional restarts.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cfg_done    = ($urandom_range(0, 9) == 0);
      qpll_lock   = ($urandom_range(0, 39) != 0);
      tx_rst_done = ($urandom_range(0, 3) != 0);
      rx_rst_done = ($urandom_range(0, 3) != 0);
      restart     = ($urandom_range(0, 299) == 0);
      tick();
    end
    restart = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_bringup_sequencer.md
Name: clk_bringup_sequencer

Overview:
Power-up and recovery sequencer for the SI5324 jitter-cleaner and GTX reference-clock path. It replaces the ad-hoc counter FSM in the top level. It drives the SI5324 hard reset and I2C mux reset, triggers the I2C auto-config block, waits for QPLL lock, then releases the GTX soft reset. It monitors lock continuously and retries the full sequence, up to a bounded count, on timeout or loss of lock.

Parameters:
RST_HOLD_CYC, 4000, cycles si_rst_n/iic_mux_rst_n held low
RECOVER_CYC, 4000, cycles waited after releasing SI5324 reset before config
CFG_PULSE_CYC, 4000, cycles reconfig is held high
CFG_TIMEOUT_CYC, 2000000, max cycles waiting for cfg_done
LOCK_FILTER_CYC, 1024, consecutive cycles qpll_lock must be high
LOCK_TIMEOUT_CYC, 20000000, max cycles in LOCK_WAIT
DONE_TIMEOUT_CYC, 20000000, max cycles waiting for tx/rx reset done
MAX_RETRIES, 3, failed attempts tolerated before FAULT (1..15)

Ports:
clk  in  1  system clock (200 MHz)
rst_n  in  1  asynchronous active-low reset
restart  in  1  synchronous pulse; restarts sequence, clears retry count
cfg_done  in  1  level from I2C config block, high when config complete
qpll_lock  in  1  GTX QPLL lock (already synchronised to clk)
tx_rst_done  in  1  GTX TX reset FSM done (synchronised)
rx_rst_done  in  1  GTX RX reset FSM done (synchronised)
si_rst_n  out  1  SI5324 reset, low = reset
iic_mux_rst_n  out  1  I2C mux reset, low = reset; always equal to si_rst_n
reconfig  out  1  config trigger to I2C auto-config block
gt_soft_reset  out  1  GTX TX/RX soft reset, high = reset
ready  out  1  clock path up and stable
fault  out  1  retries exhausted
retry_cnt  out  4  failed attempts in current run
state_out  out  3  current state encoding, for ILA

Behaviour:
- Reset (rst_n low, async): state=RESET_HOLD, timer=0, filter=0, retry_cnt=0. Outputs: si_rst_n=0, iic_mux_rst_n=0, reconfig=0, gt_soft_reset=1, ready=0, fault=0.
- Outputs are a Moore decode of the registered state. They change in the same cycle as the state. Cycle 0 is the first rising edge with rst_n high.
- One 32-bit timer, cleared on every state transition, incrementing otherwise. "Hold N" means the state lasts exactly N cycles: exit when timer==N-1.
- States (encoding 0..7):
  - RESET_HOLD(0): si_rst_n=0. Hold RST_HOLD_CYC, then RECOVER.
  - RECOVER(1): si_rst_n=1. Hold RECOVER_CYC, then CONFIG.
  - CONFIG(2): reconfig=1. Hold CFG_PULSE_CYC, then CFG_WAIT.
  - CFG_WAIT(3): if cfg_done is sampled high, go to LOCK_WAIT next cycle. If timer==CFG_TIMEOUT_CYC-1, fail.
  - LOCK_WAIT(4): filter counts consecutive high qpll_lock samples and resets to 0 on any low sample. When filter reaches LOCK_FILTER_CYC, go to GT_RELEASE. If timer==LOCK_TIMEOUT_CYC-1 first, fail.
  - GT_RELEASE(5): gt_soft_reset=0. If tx_rst_done&rx_rst_done is sampled high, go to READY. If timer==DONE_TIMEOUT_CYC-1, fail.
  - READY(6): gt_soft_reset=0, ready=1. qpll_lock sampled low means fail.
  - FAULT(7): fault=1, all resets asserted (si_rst_n=0, gt_soft_reset=1). Stays until restart or rst_n.
- gt_soft_reset=1 in all states except GT_RELEASE and READY. si_rst_n=1 in all states except RESET_HOLD and FAULT.
- Fail: retry_cnt+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_HOLD. retry_cnt saturates, never wraps.
- Entering READY does not clear retry_cnt. Only restart or rst_n clears it.
- restart (any state, including FAULT) goes to RESET_HOLD, retry_cnt=0, and takes priority over a same-cycle fail or success exit.
- Simultaneous success and timeout in the same cycle: success wins.

Test Plan:
Overrides for all scenarios: RST_HOLD=4, RECOVER=4, CFG_PULSE=2, CFG_TIMEOUT=20, LOCK_FILTER=3, LOCK_TIMEOUT=20, DONE_TIMEOUT=20, MAX_RETRIES=2.
1. Clean bring-up: cfg_done, qpll_lock, tx/rx done all held high.
   -> si_rst_n rises at cycle 4, reconfig high cycles 8-9, gt_soft_reset falls at cycle 14, ready=1 from cycle 15, retry_cnt=0.
2. Lock glitch: qpll_lock low for 1 cycle at LOCK_WAIT entry+1.
   -> filter restarts; GT_RELEASE entered 2 cycles later than in scenario 1.
3. cfg_done never asserted.
   -> fail at CFG_WAIT timer 19, retry_cnt=1, back to RESET_HOLD. The second timeout gives fault=1, retry_cnt=2, si_rst_n=0, gt_soft_reset=1.
4. Lock loss in READY: drop qpll_lock for 1 cycle.
   -> ready=0 next cycle, state_out=0, retry_cnt=1; sequence reruns to READY.
5. Restart asserted in FAULT, and separately at the same cycle as a CFG_WAIT timeout.
   -> RESET_HOLD, retry_cnt=0, fault=0 in both cases.
6. rst_n pulsed low mid-CONFIG (asynchronous, between edges).
   -> reconfig=0, si_rst_n=0, gt_soft_reset=1 immediately; sequence restarts from cycle 0.
